usb_rx_packet_ctrl: RTL and testbench



---
 rtl/usb_rx_packet_ctrl.sv | 164 ++++++++++++++++
 tb/tb_usb_rx_packet_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_ctrl.sv
// usb_rx_packet_ctrl: USB receive bit-path sequencer (SYNC, destuff, bytes, framing).
// Ports: clk, nRST (async low); rx_bit/rx_valid/rx_se0 in; byte_out/byte_valid,
//        pkt_start/pkt_end/rx_error strobes, rx_active, byte_count out.
module usb_rx_packet_ctrl #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int MAX_BYTES      = 1026
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        rx_bit,
  input  logic        rx_valid,
  input  logic        rx_se0,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        pkt_start,
  output logic        pkt_end,
  output logic        rx_error,
  output logic        rx_active,
  output logic [10:0] byte_count
);

  localparam logic [2:0]  ZMIN = 3'(SYNC_MIN_ZEROS);
  localparam logic [10:0] MAXB = 11'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  zero_cnt_q, zero_cnt_d;
  logic [2:0]  one_cnt_q, one_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic        pkt_start_q, pkt_start_d;
  logic        pkt_end_q, pkt_end_d;
  logic        rx_error_q, rx_error_d;
  logic        rx_active_q, rx_active_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic [7:0]  shift_nxt;

  always_comb begin
    state_d      = state_q;
    zero_cnt_d   = zero_cnt_q;
    one_cnt_d    = one_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_out_d   = byte_out_q;
    byte_count_d = byte_count_q;
    byte_valid_d = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_end_d    = 1'b0;
    rx_error_d   = 1'b0;
    shift_nxt    = {rx_bit, shift_q[7:1]};
    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_se0 && !rx_bit) begin
            state_d    = S_SYNC;
            zero_cnt_d = 3'd1;
          end
        end
        S_SYNC: begin
          if (rx_se0) begin
            state_d = S_IDLE;
          end else if (!rx_bit) begin
            if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
          end else if (zero_cnt_q >= ZMIN) begin
            state_d      = S_DATA;
            pkt_start_d  = 1'b1;
            byte_count_d = '0;
            one_cnt_d    = 3'd1;
            bit_cnt_d    = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (rx_se0) begin
            // A pending stuff position at SE0 is not an error.
            state_d    = S_EOP;
            pkt_end_d  = 1'b1;
            rx_error_d = (bit_cnt_q != 3'd0);
          end else if (one_cnt_q == 3'd6) begin
            // Stuffed position: a 0 is dropped, a 1 is a stuff error.
            if (rx_bit) begin
              state_d    = S_ERR;
              rx_error_d = 1'b1;
            end else begin
              one_cnt_d = '0;
            end
          end else begin
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            one_cnt_d = rx_bit ? one_cnt_q + 3'd1 : 3'd0;
            if (bit_cnt_q == 3'd7) begin
              if (byte_count_q == MAXB) begin
                state_d    = S_ERR;
                rx_error_d = 1'b1;
              end else begin
                byte_out_d   = shift_nxt;
                byte_valid_d = 1'b1;
                byte_count_d = byte_count_q + 11'd1;
              end
            end
          end
        end
        S_EOP: begin
          if (!rx_se0) state_d = S_IDLE;
        end
        S_ERR: begin
          // After the SE0, EOP does the same wait-for-J, silently.
          if (rx_se0) state_d = S_EOP;
        end
        default: state_d = S_IDLE;
      endcase
    end
    rx_active_d = (state_d == S_DATA);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      zero_cnt_q   <= '0;
      one_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      rx_error_q   <= 1'b0;
      rx_active_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      zero_cnt_q   <= zero_cnt_d;
      one_cnt_q    <= one_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pkt_start_q  <= pkt_start_d;
      pkt_end_q    <= pkt_end_d;
      rx_error_q   <= rx_error_d;
      rx_active_q  <= rx_active_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign pkt_start  = pkt_start_q;
  assign pkt_end    = pkt_end_q;
  assign rx_error   = rx_error_q;
  assign rx_active  = rx_active_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// tb_usb_rx_packet_ctrl: randomized packets vs. a packet-level expected-event model.
// Stimulus is built as logical bytes, bit-stuffed on the wire; events are checked in order.
module tb_usb_rx_packet_ctrl;

  localparam int ZMIN = 5;
  localparam int MAXB = 1026;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        rx_bit = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_se0 = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        pkt_start;
  logic        pkt_end;
  logic        rx_error;
  logic        rx_active;
  logic [10:0] byte_count;

  usb_rx_packet_ctrl #(.SYNC_MIN_ZEROS(ZMIN), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .nRST(nRST), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .rx_se0(rx_se0), .byte_out(byte_out), .byte_valid(byte_valid),
    .pkt_start(pkt_start), .pkt_end(pkt_end), .rx_error(rx_error),
    .rx_active(rx_active), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // kind: 0 start, 1 byte, 2 end (err = partial byte), 3 error without end
  typedef struct {
    int         kind;
    logic [7:0] val;
    logic       err;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] blog[$];
  bit         dbits[$];
  int nchk = 0, npass = 0;
  int n_start = 0, n_end = 0, n_end_err = 0, n_errs = 0;
  logic       in_pkt = 1'b0;
  int         mcnt = 0;
  logic [7:0] mlast = 8'h00;
  logic       lv = 1'b0;
  int         gap_max = 2;
  logic [7:0] m_acc;
  int         m_nacc, m_nb;
  bit         m_dead;
  logic [0:17] w_ff = 18'b111110111111011110;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic take(input string nm, input int kind, output ev_t e);
    e.kind = -1; e.val = 8'h00; e.err = 1'b0;
    if (exp_q.size() == 0) chk({nm, "_spurious"}, 1, 0);
    else begin
      e = exp_q.pop_front();
      chk({nm, "_order"}, kind, e.kind);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!nRST) begin
      exp_q.delete();
      in_pkt = 1'b0; mcnt = 0; mlast = 8'h00;
    end else begin
      chk("strobe_needs_sample",
          (pkt_start | byte_valid | pkt_end | rx_error) & ~lv, 0);
      if (pkt_start) begin
        n_start++; take("start", 0, e); in_pkt = 1'b1; mcnt = 0;
      end
      if (byte_valid) begin
        take("byte", 1, e); chk("byte_val", byte_out, e.val);
        mcnt++; mlast = e.val; blog.push_back(byte_out);
      end
      if (pkt_end) begin
        n_end++; if (rx_error) n_end_err++;
        take("end", 2, e); chk("end_err", rx_error, e.err); in_pkt = 1'b0;
      end else if (rx_error) begin
        n_errs++; take("err", 3, e); in_pkt = 1'b0;
      end
      chk("rx_active", rx_active, in_pkt);
      chk("byte_count", byte_count, mcnt);
      chk("byte_out_hold", byte_out, mlast);
    end
    lv = rx_valid;
  end

  task automatic push(input int k, input logic [7:0] v, input logic er);
    ev_t e;
    e.kind = k; e.val = v; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic se0, input logic b);
    int g;
    g = $urandom_range(gap_max, 0);
    repeat (g) begin
      rx_valid = 1'b0; rx_bit = 1'($urandom); rx_se0 = 1'($urandom);
      @(posedge clk); #1;
    end
    rx_valid = 1'b1; rx_se0 = se0; rx_bit = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) dbits.push_back(b[i]);
  endtask

  task automatic accept(input bit b);
    if (!m_dead) begin
      m_acc = {b, m_acc[7:1]};
      m_nacc++;
      if (m_nacc % 8 == 0) begin
        m_nb++;
        if (m_nb > MAXB) begin push(3, 8'h00, 1'b0); m_dead = 1'b1; end
        else push(1, m_acc, 1'b0);
      end
    end
  endtask

  task automatic run_packet(input int nz, input bit serr, input bit drop_tail,
                            input int nse0);
    int run;
    repeat (nz) send(1'b0, 1'b0);
    if (nz < ZMIN) begin
      repeat (4) send(1'b0, 1'b1);
      return;
    end
    push(0, 8'h00, 1'b0);
    send(1'b0, 1'b1);
    run = 1; m_acc = 8'h00; m_nacc = 0; m_nb = 0; m_dead = 1'b0;
    for (int i = 0; i < dbits.size(); i++) begin
      send(1'b0, dbits[i]);
      accept(dbits[i]);
      run = dbits[i] ? run + 1 : 0;
      if (run == 6 && !(drop_tail && i == dbits.size() - 1)) begin
        send(1'b0, 1'b0);
        run = 0;
      end
    end
    if (serr && !m_dead) begin
      while (run < 6 && !m_dead) begin
        send(1'b0, 1'b1); accept(1'b1); run++;
      end
      if (!m_dead) begin
        push(3, 8'h00, 1'b0);
        send(1'b0, 1'b1);
        m_dead = 1'b1;
      end
      repeat ($urandom_range(5, 0)) send(1'b0, 1'($urandom));
    end
    if (!m_dead) push(2, 8'h00, (m_nacc % 8) != 0);
    repeat (nse0) send(1'b1, 1'b0);
    repeat (3) send(1'b0, 1'b1);
  endtask

  initial begin
    int s0, s1, s2, s3, s4;
    nRST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_out", byte_out, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_rx_active", rx_active, 0);
    chk("rst_strobes", {byte_valid, pkt_start, pkt_end, rx_error}, 0);
    nRST = 1'b1;
    @(posedge clk); #1;

    s0 = n_start; s1 = n_end; s2 = n_errs; s3 = blog.size();
    dbits.delete(); load_byte(8'hA5); load_byte(8'h3C);
    run_packet(7, 1'b0, 1'b0, 2);
    chk("a5_starts", n_start - s0, 1);
    chk("a5_ends", n_end - s1, 1);
    chk("a5_errs", n_errs - s2, 0);
    chk("a5_nbytes", blog.size() - s3, 2);
    chk("a5_byte0", blog[blog.size() - 2], 8'hA5);
    chk("a5_byte1", blog[blog.size() - 1], 8'h3C);
    chk("a5_count", byte_count, 2);

    s3 = blog.size();
    push(0, 8'h00, 1'b0); push(1, 8'hFF, 1'b0);
    push(1, 8'h7F, 1'b0); push(2, 8'h00, 1'b0);
    repeat (7) send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    for (int i = 0; i < 18; i++) send(1'b0, w_ff[i]);
    repeat (2) send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    chk("ff_nbytes", blog.size() - s3, 2);
    chk("ff_byte0", blog[blog.size() - 2], 8'hFF);
    chk("ff_byte1", blog[blog.size() - 1], 8'h7F);

    s0 = n_start; s1 = n_end; s2 = n_errs; s3 = blog.size();
    dbits.delete();
    run_packet(6, 1'b1, 1'b0, 1);
    chk("stuff_errs", n_errs - s2, 1);
    chk("stuff_ends", n_end - s1, 0);
    chk("stuff_nbytes", blog.size() - s3, 0);
    chk("stuff_active", rx_active, 0);
    dbits.delete(); load_byte(8'h5A);
    run_packet(5, 1'b0, 1'b0, 2);
    chk("after_err_byte", blog[blog.size() - 1], 8'h5A);

    s0 = n_start;
    dbits.delete();
    run_packet(3, 1'b0, 1'b0, 1);
    chk("sync3_starts", n_start - s0, 0);
    run_packet(5, 1'b0, 1'b0, 1);
    chk("sync5_starts", n_start - s0, 1);

    s4 = n_end_err;
    dbits.delete(); load_byte(8'hA5);
    for (int i = 0; i < 4; i++) dbits.push_back(i[1]);
    run_packet(5, 1'b0, 1'b0, 2);
    chk("partial_end_err", n_end_err - s4, 1);
    chk("partial_count", byte_count, 1);

    push(0, 8'h00, 1'b0); push(1, 8'hA5, 1'b0);
    repeat (5) send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    dbits.delete(); load_byte(8'hA5); load_byte(8'h05);
    for (int i = 0; i < 12; i++) send(1'b0, dbits[i]);
    chk("mid_active", rx_active, 1);
    #2 nRST = 1'b0;
    #1;
    chk("arst_byte_out", byte_out, 0);
    chk("arst_byte_count", byte_count, 0);
    chk("arst_active", rx_active, 0);
    chk("arst_strobes", {byte_valid, pkt_start, pkt_end, rx_error}, 0);
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    dbits.delete(); load_byte(8'h3C);
    run_packet(5, 1'b0, 1'b0, 2);
    chk("post_rst_byte", blog[blog.size() - 1], 8'h3C);
    chk("post_rst_count", byte_count, 1);

    for (int p = 0; p < 40; p++) begin
      int nb;
      dbits.delete();
      nb = $urandom_range(4, 0);
      for (int k = 0; k < nb; k++)
        load_byte(($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom));
      if ($urandom_range(3, 0) == 0)
        repeat ($urandom_range(7, 1)) dbits.push_back(1'($urandom));
      run_packet($urandom_range(8, 3), $urandom_range(4, 0) == 0,
                 1'($urandom), $urandom_range(2, 1));
    end

    s1 = n_end; s2 = n_errs;
    gap_max = 0;
    dbits.delete();
    for (int k = 0; k < MAXB + 1; k++) load_byte(8'($urandom));
    run_packet(5, 1'b0, 1'b0, 2);
    gap_max = 2;
    chk("ovl_count", byte_count, MAXB);
    chk("ovl_errs", n_errs - s2, 1);
    chk("ovl_ends", n_end - s1, 0);

    repeat (5) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
